// File: rtl/cpu_pkg.sv
// Shared definitions for the bit-serial CPU front end: loader state encoding,
// instruction/nibble geometry and the opcode field position.
package cpu_pkg;

    localparam int INSTR_W        = 16;
    localparam int NIB_W          = 4;
    localparam int NIBS_PER_INSTR = 4;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 3;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } ld_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchroniser, debouncer and rise detector.
// Define INST_LOADER_DEBOUNCE_EN to enable the persistence counter; otherwise stable follows s2.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn_raw,
    output logic rise
);

    // Constant 1 for every legal setting; an illegal count simply yields no events.
    localparam logic DB_OK = (DEBOUNCE_CYCLES >= 1);

    logic r_s1;
    logic r_s2;
    logic r_stable;
    logic r_stable_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_stable_d <= 1'b0;
        end else begin
            r_s1       <= btn_raw;
            r_s2       <= r_s1;
            r_stable_d <= r_stable;
        end
    end

`ifdef INST_LOADER_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;

    // A changed level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_s2 != r_stable) begin
            if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end
`else
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stable <= 1'b0;
        end else begin
            r_stable <= r_s2;
        end
    end
`endif

    assign rise = r_stable & ~r_stable_d & DB_OK;

endmodule

// File: rtl/inst_loader.sv
// Instruction entry stage: debounced button, nibble loader FSM and execute pulse.
// Debounce counter is enabled by defining INST_LOADER_DEBOUNCE_EN.
module inst_loader
    import cpu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   btn_raw,
    input  logic                   load_mode,
    input  logic [NIB_W-1:0]       nib_in,
    input  logic                   cpu_busy,
    output logic [NIB_W-1:0]       opcode,
    output logic [INSTR_W-NIB_W-1:0] instr,
    output logic                   inst_done,
    output logic                   btn_edge,
    output logic [2:0]             nib_count,
    output ld_state_t              dbg_state
);

    logic w_rise;
    logic w_load_ev;
    logic w_exec_ev;
    logic w_shift;
    logic [2:0] w_cnt_next;
    ld_state_t w_next_state;

    ld_state_t          r_state;
    logic [2:0]         r_cnt;
    logic [INSTR_W-1:0] r_sr;
    logic               r_btn_edge;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk     (clk),
        .rstn    (rstn),
        .btn_raw (btn_raw),
        .rise    (w_rise)
    );

    // A rise seen while the CPU is busy is dropped, never queued.
    assign w_load_ev = w_rise &  load_mode & ~cpu_busy;
    assign w_exec_ev = w_rise & ~load_mode & ~cpu_busy;

    always_comb begin
        w_next_state = r_state;
        w_shift      = 1'b0;
        w_cnt_next   = r_cnt;
        case (r_state)
            EMPTY: begin
                if (w_load_ev) begin
                    w_shift      = 1'b1;
                    w_cnt_next   = 3'd1;
                    w_next_state = LOADING;
                end
            end
            LOADING: begin
                if (w_load_ev) begin
                    w_shift    = 1'b1;
                    w_cnt_next = r_cnt + 3'd1;
                    if (r_cnt == 3'(NIBS_PER_INSTR - 1)) begin
                        w_next_state = READY;
                    end
                end else if (!load_mode) begin
                    w_cnt_next   = 3'd0;
                    w_next_state = EMPTY;
                end
            end
            READY: begin
                if (w_load_ev) begin
                    w_shift      = 1'b1;
                    w_cnt_next   = 3'd1;
                    w_next_state = LOADING;
                end
            end
            default: begin
                w_cnt_next   = 3'd0;
                w_next_state = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= EMPTY;
            r_cnt      <= 3'd0;
            r_sr       <= '0;
            r_btn_edge <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_cnt_next;
            r_btn_edge <= w_exec_ev;
            if (w_shift) begin
                r_sr <= {r_sr[INSTR_W-NIB_W-1:0], nib_in};
            end
        end
    end

    assign opcode    = r_sr[OPCODE_MSB:OPCODE_LSB];
    assign instr     = r_sr[INSTR_W-1:NIB_W];
    assign inst_done = (r_state == READY);
    assign btn_edge  = r_btn_edge;
    assign nib_count = r_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed scenarios plus randomized presses,
// all compared every cycle against a behavioural model of the entry stage.
module tb_inst_loader;

    localparam int N = 16;
`ifdef INST_LOADER_DEBOUNCE_EN
    localparam int EFF_N = N;
`else
    localparam int EFF_N = 1;
`endif

    logic        clk;
    logic        rstn;
    logic        btn_raw;
    logic        load_mode;
    logic [3:0]  nib_in;
    logic        cpu_busy;
    logic [3:0]  opcode;
    logic [11:0] instr;
    logic        inst_done;
    logic        btn_edge;
    logic [2:0]  nib_count;
    cpu_pkg::ld_state_t dbg_state;

    inst_loader #(
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .btn_raw   (btn_raw),
        .load_mode (load_mode),
        .nib_in    (nib_in),
        .cpu_busy  (cpu_busy),
        .opcode    (opcode),
        .instr     (instr),
        .inst_done (inst_done),
        .btn_edge  (btn_edge),
        .nib_count (nib_count),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int p0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Button: 2-stage sync, level accepted after EFF_N consecutive differing samples.
    // Loader: 16-bit instruction built by shifting nibbles in; count 0..4, 4 = done.
    logic        m_s1, m_s2, m_stable, m_stable_d, m_btn_edge;
    bit          m_hist[$];
    logic [15:0] m_sr;
    int          m_cnt;
    logic        t_rise, t_load, t_exec, t_alldiff;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_s1 = 0; m_s2 = 0; m_stable = 0; m_stable_d = 0; m_btn_edge = 0;
            m_sr = 16'h0; m_cnt = 0;
            m_hist.delete();
        end else begin
            t_rise = m_stable & ~m_stable_d;
            t_load = t_rise & load_mode & ~cpu_busy;
            t_exec = t_rise & ~load_mode & ~cpu_busy;
            m_btn_edge = t_exec;
            if (t_load) begin
                m_sr  = {m_sr[11:0], nib_in};
                m_cnt = (m_cnt == 4) ? 1 : m_cnt + 1;
            end else if (m_cnt >= 1 && m_cnt <= 3 && !load_mode) begin
                m_cnt = 0;
            end
            m_stable_d = m_stable;
            m_hist.push_back(m_s2);
            if (m_hist.size() > EFF_N) void'(m_hist.pop_front());
            if (m_hist.size() == EFF_N) begin
                t_alldiff = 1'b1;
                foreach (m_hist[i]) if (m_hist[i] == m_stable) t_alldiff = 1'b0;
                if (t_alldiff) m_stable = m_s2;
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rstn) begin
            check("opcode",    32'(opcode),    32'(m_sr[3:0]));
            check("instr",     32'(instr),     32'(m_sr[15:4]));
            check("inst_done", 32'(inst_done), 32'(m_cnt == 4));
            check("btn_edge",  32'(btn_edge),  32'(m_btn_edge));
            check("nib_count", 32'(nib_count), 32'(m_cnt));
            check("dbg_state", 32'(dbg_state), (m_cnt == 0) ? 32'd0 : (m_cnt == 4) ? 32'd2 : 32'd1);
            if (btn_edge) pulse_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] nib);
        @(negedge clk);
        nib_in  = nib;
        btn_raw = 1'b1;
        repeat (EFF_N + 4) @(negedge clk);
        btn_raw = 1'b0;
        repeat (EFF_N + 6) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_opcode"},    32'(opcode),    32'd0);
        check({tag, "_instr"},     32'(instr),     32'd0);
        check({tag, "_inst_done"}, 32'(inst_done), 32'd0);
        check({tag, "_btn_edge"},  32'(btn_edge),  32'd0);
        check({tag, "_nib_count"}, 32'(nib_count), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn = 1'b0; btn_raw = 1'b0; load_mode = 1'b0; nib_in = 4'h0; cpu_busy = 1'b0;
        #1;
        check_all_zero("reset");
        idle(3);
        rstn = 1'b1;
        idle(2);

        // Load 1,2,3,8.
        load_mode = 1'b1;
        press(4'h1);
        check("load1_count", 32'(nib_count), 32'd1);
        press(4'h2);
        press(4'h3);
        check("load3_done", 32'(inst_done), 32'd0);
        press(4'h8);
        check("load4_instr",  32'(instr),     32'h123);
        check("load4_opcode", 32'(opcode),    32'h8);
        check("load4_done",   32'(inst_done), 32'd1);
        check("load4_count",  32'(nib_count), 32'd4);
        check("model_sr",     32'(m_sr),      32'h1238);

        // Execute latency: press first sampled at edge k, held 20 cycles.
        load_mode = 1'b0;
        idle(2);
        p0 = pulse_cnt;
        btn_raw = 1'b1;
        for (int j = 0; j < 30; j++) begin
            @(posedge clk);
            #1;
            check("exec_timing", 32'(btn_edge), 32'(j == 2 + EFF_N));
            if (j == 19) btn_raw = 1'b0;
        end
        idle(EFF_N + 6);
        check("exec_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("exec_keeps_done", 32'(inst_done), 32'd1);

        // 15-cycle glitch: filtered only when debouncing.
        p0 = pulse_cnt;
        @(negedge clk);
        btn_raw = 1'b1;
        repeat (15) @(negedge clk);
        btn_raw = 1'b0;
        idle(EFF_N + 8);
        check("glitch_pulses", 32'(pulse_cnt - p0), (EFF_N > 15) ? 32'd0 : 32'd1);

        // Busy drops the press.
        cpu_busy = 1'b1;
        p0 = pulse_cnt;
        press(4'hF);
        check("busy_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("busy_instr",  32'(instr), 32'h123);
        cpu_busy = 1'b0;

        // Abort after two nibbles.
        load_mode = 1'b1;
        press(4'hA);
        press(4'hB);
        check("abort_pre_count", 32'(nib_count), 32'd2);
        @(negedge clk);
        load_mode = 1'b0;
        idle(2);
        check("abort_count", 32'(nib_count), 32'd0);
        check("abort_done",  32'(inst_done), 32'd0);
        p0 = pulse_cnt;
        press(4'h0);
        check("abort_exec_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("abort_exec_done",   32'(inst_done), 32'd0);

        // Asynchronous reset after three nibbles.
        load_mode = 1'b1;
        press(4'hC);
        press(4'hD);
        press(4'hE);
        check("prereset_count", 32'(nib_count), 32'd3);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("midreset");
        idle(2);
        rstn = 1'b1;
        idle(2);
        press(4'h4);
        press(4'h5);
        press(4'h6);
        press(4'h7);
        check("reload_instr",  32'(instr),  32'h456);
        check("reload_opcode", 32'(opcode), 32'h7);
        check("reload_done",   32'(inst_done), 32'd1);

        // Randomized presses, glitches, busy and mode changes.
        for (int it = 0; it < 200; it++) begin
            @(negedge clk);
            load_mode = ($urandom_range(0, 3) != 0);
            cpu_busy  = ($urandom_range(0, 4) == 0);
            nib_in    = 4'($urandom_range(0, 15));
            btn_raw   = 1'b1;
            repeat ($urandom_range(1, EFF_N + 4)) @(negedge clk);
            btn_raw = 1'b0;
            if ($urandom_range(0, 5) == 0) load_mode = ~load_mode;
            repeat ($urandom_range(1, EFF_N + 4)) @(negedge clk);
        end
        idle(EFF_N + 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
